// File: rtl/actfunc_pkg.sv
// Shared types and Q8.8 constants for the activation-stage feeders.
package actfunc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FP    = 8;

  localparam int Q_ONE   = 256;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_ROUND,
    S_OUT
  } mac_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Round-half-up a fixed-point value, drop FP fraction bits,
// and saturate it into a signed OUT_W word with a clip flag.
module q_round_sat #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16,
  parameter int FP    = 8
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    clip_o
);

  localparam int SW = IN_W + 1;

  localparam logic signed [SW-1:0] HALF =
    {{(SW-FP){1'b0}}, 1'b1, {(FP-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] r;

  // One guard bit keeps the rounding add from wrapping.
  assign sum = {x_i[IN_W-1], x_i} + HALF;
  assign r   = sum >>> FP;

  always_comb begin
    y_o    = r[OUT_W-1:0];
    clip_o = 1'b0;
    if (r > MAXV) begin
      y_o    = MAXV[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (r < MINV) begin
      y_o    = MINV[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_q88.sv
// Streaming Q8.8 dot product plus bias with a 2-stage MAC,
// rounded and saturated result handed out over valid/ready.
module neuron_mac_q88
  import actfunc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FP        = DEF_FP,
  parameter int MAX_LEN   = 256,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(MAX_LEN),
  parameter int LEN_W     = $clog2(MAX_LEN+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [WIDTH-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat,
  output logic                    busy
);

  localparam int PW = 2 * WIDTH;

  mac_state_e state_q;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [PW-1:0]        prod_q;
  logic                        prodv_q;
  logic [LEN_W-1:0]            cnt_q;
  logic [LEN_W-1:0]            len_q;
  logic signed [WIDTH-1:0]     y_q;
  logic                        sat_q;
  logic                        ov_q;

  logic [LEN_W-1:0]            cnt_d;
  logic [LEN_W-1:0]            len_c;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [WIDTH-1:0]     rs_y;
  logic                        rs_clip;
  logic                        take;

  assign cnt_d    = cnt_q + 1'b1;
  assign len_c    = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign prod_ext = ACC_WIDTH'(prod_q);
  assign in_ready = (state_q == S_ACCUM) && (cnt_q < len_q);
  assign take     = in_valid && in_ready;

  q_round_sat #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (WIDTH),
    .FP    (FP)
  ) u_rs (
    .x_i    (acc_q),
    .y_o    (rs_y),
    .clip_o (rs_clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      prodv_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= ACC_WIDTH'(bias) <<< FP;
            cnt_q   <= '0;
            len_q   <= len_c;
            state_q <= (len_c != '0) ? S_ACCUM : S_ROUND;
          end
        end
        S_ACCUM: begin
          if (prodv_q) acc_q <= acc_q + prod_ext;
          if (take) begin
            prod_q  <= PW'(a) * PW'(w);
            prodv_q <= 1'b1;
            cnt_q   <= cnt_d;
            if (cnt_d == len_q) state_q <= S_FLUSH;
          end else begin
            prodv_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (prodv_q) acc_q <= acc_q + prod_ext;
          prodv_q <= 1'b0;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          y_q     <= rs_y;
          sat_q   <= rs_clip;
          ov_q    <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign sat       = sat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_q88.sv
// Directed bench for neuron_mac_q88 with an arithmetic reference
// model, a per-cycle output checker and literal expectations.
module tb_neuron_mac_q88;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [8:0]         len;
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a;
  logic signed [15:0] w;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y;
  logic               sat;
  logic               busy;

  typedef struct {
    longint y;
    longint sat;
  } exp_t;

  exp_t   expq[$];
  int     pa[8];
  int     pw[8];
  int     vectors = 0;
  int     errors  = 0;
  longint cyc     = 0;

  neuron_mac_q88 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Exact real-number result, rounded half-up and clipped.
  function automatic exp_t model(input int n, input int b);
    exp_t   e;
    longint s;
    longint r;
    s = longint'(b) * 256;
    for (int k = 0; k < n; k++)
      s += longint'(pa[k]) * longint'(pw[k]);
    r = (s + 128) >>> 8;
    e.sat = 0;
    e.y   = r;
    if (r > 32767) begin
      e.y = 32767; e.sat = 1;
    end else if (r < -32768) begin
      e.y = -32768; e.sat = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_out: got y=%0d want no result", y);
      end else begin
        chk("y", y, expq[0].y);
        chk("sat", sat, expq[0].sat);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && expq.size() != 0)
      void'(expq.pop_front());
  end

  task automatic run(input int n, input int b, input int gap,
                     input int hold, input int ly, input int lsat,
                     input bit lit);
    longint c0;
    int     t;
    int     g;
    int     want;
    expq.push_back(model(n, b));
    out_ready = (hold == 0);
    start     = 1'b1;
    len       = 9'(n);
    bias      = 16'(b);
    @(negedge clk);
    start = 1'b0;
    c0    = cyc;
    g     = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int j = 0; j < gap; j++) begin
          in_valid = 1'b0;
          @(negedge clk);
          g++;
        end
      end
      in_valid = 1'b1;
      a = 16'(pa[k]);
      w = 16'(pw[k]);
      if (k == 0) chk("in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      vectors++;
      errors++;
      $display("FAIL timeout: got no out_valid want it within 100");
      expq.delete();
      return;
    end
    want = (n == 0) ? 1 : n + 2 + g;
    chk("latency", cyc - c0, want);
    if (lit) begin
      chk("y_lit", y, ly);
      chk("sat_lit", sat, lsat);
    end
    if (hold > 0) begin
      start = 1'b1;
      len   = 9'd1;
      bias  = 16'sd5;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_busy", busy, 0);
      start = 1'b0;
      @(negedge clk);
      chk("hold_idle", busy, 0);
    end else begin
      @(negedge clk);
      chk("ov_clr", out_valid, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    bias      = '0;
    in_valid  = 1'b0;
    a         = '0;
    w         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;
    @(negedge clk);

    pa[0] = 256; pw[0] = 512;
    run(1, 0, 0, 0, 512, 0, 1);

    pa[0] = 256;  pw[0] = 512;
    pa[1] = 128;  pw[1] = 128;
    pa[2] = -256; pw[2] = 256;
    run(3, 256, 0, 0, 576, 0, 1);
    run(3, 256, 2, 0, 576, 0, 1);

    pa[0] = 1;  pw[0] = 128;
    run(1, 0, 0, 0, 1, 0, 1);
    pa[0] = -1; pw[0] = 128;
    run(1, 0, 0, 0, 0, 0, 1);
    pa[0] = -1; pw[0] = 129;
    run(1, 0, 0, 0, -1, 0, 1);

    for (int k = 0; k < 4; k++) begin
      pa[k] = 32767; pw[k] = 32767;
    end
    run(4, 0, 0, 0, 32767, 1, 1);
    pa[0] = 32767; pw[0] = -32768;
    run(1, -32768, 0, 0, -32768, 1, 1);

    pa[0] = 256; pw[0] = 512;
    run(1, 0, 0, 5, 512, 0, 1);

    run(0, -300, 0, 0, -300, 0, 1);

    pa[0] = 300;   pw[0] = -77;
    pa[1] = -1000; pw[1] = 45;
    pa[2] = 12345; pw[2] = 3;
    pa[3] = -5;    pw[3] = -6000;
    pa[4] = 700;   pw[4] = 700;
    run(5, -1234, 1, 0, 0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      pa[k] = 256; pw[k] = 256;
    end
    start = 1'b1;
    len   = 9'd4;
    bias  = 16'sd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      a = 16'(pa[k]);
      w = 16'(pw[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ov", out_valid, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_y", y, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("arst_quiet", busy, 0);

    pa[0] = 256; pw[0] = 256;
    run(1, 0, 0, 0, 256, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_q88.md
Name: neuron_mac_q88

Overview:
- Upstream feeder for the pipelined softplus activation stage.
- Computes one neuron pre-activation: y = bias + sum(a[k]*w[k]) for k = 0..len-1, all values in signed Q8.8.
- Streams operand pairs over a valid/ready handshake, accumulates at full precision, then applies round-half-up and saturation to a 16-bit Q8.8 word.
- Presents the result with out_valid/out_ready. Downstream, y drives the activation x input directly.

Parameters:
- WIDTH, 16, operand/result width (signed Q(WIDTH-FP).FP)
- FP, 8, fractional bits
- MAX_LEN, 256, maximum terms per dot product
- ACC_WIDTH, 2*WIDTH+$clog2(MAX_LEN), accumulator width; no internal overflow by construction

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a new dot product; accepted only in IDLE
- len  in  $clog2(MAX_LEN+1)  term count, sampled on accepted start; values > MAX_LEN clamp to MAX_LEN
- bias  in  WIDTH  signed Q8.8 bias, sampled on accepted start
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  WIDTH  signed activation operand
- w  in  WIDTH  signed weight operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result (tie 1 when feeding the activation stage)
- y  out  WIDTH  signed Q8.8 result
- sat  out  1  result was saturated; qualified by out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high (rst); the clock is clk.
- Reset values: state=IDLE; in_ready, out_valid, sat, busy = 0; y=0; acc=0; prod_v=0; cnt=0.
- States: IDLE, ACCUM, FLUSH, ROUND, OUT.
- IDLE:
  - in_ready=0.
  - On start at edge E0: acc <= sign_ext(bias) << FP; cnt <= 0; latch len.
  - Next state is ACCUM if len != 0, else ROUND.
- ACCUM:
  - in_ready=1 while cnt < len.
  - A term is accepted on in_valid && in_ready.
  - On accept: prod_reg <= a*w (signed, 2*WIDTH, Q16.16); prod_v <= 1; cnt++. Otherwise prod_v <= 0.
  - Every edge where prod_v=1: acc <= acc + sign_ext(prod_reg). This is a 2-stage multiply/accumulate pipeline.
  - The accept that makes cnt==len moves to FLUSH. in_ready is combinationally 0 in FLUSH.
  - Gaps in in_valid stall without loss.
- FLUSH: absorbs the last product (acc += prod_reg), clears prod_v, goes to ROUND. Lasts exactly 1 cycle.
- ROUND:
  - r = (acc + (1 << (FP-1))) >>> FP.
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - y <= sat value; sat <= (r was clipped); out_valid <= 1; go to OUT.
- OUT:
  - y and sat are held stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0; go to IDLE.
  - A start in the same cycle is ignored; it is accepted in IDLE on the next cycle.
- Latency with continuous in_valid: terms are accepted at E1..EN; out_valid is high after E(N+2).
  - Back-to-back throughput: N+4 cycles per neuron with out_ready=1.
- len=0: out_valid is high after E1; y = bias; sat=0.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored, since in_ready=0.
- Reset mid-operation aborts immediately: all state returns to reset values, and no partial result is emitted.

Decomposition:
- Shared package (actfunc_pkg):
  - WIDTH and FP defaults
  - Q8.8 constants: Q_ONE=256, SAT_MAX=32767, SAT_MIN=-32768
  - state enum/localparams for IDLE/ACCUM/FLUSH/ROUND/OUT
- One sub-module: q_round_sat. Purely combinational, parameters IN_W, OUT_W, FP. Rounds half-up, saturates, outputs value plus clip flag. Reusable by other activation-stage feeders.

Test Plan:
- len=1, bias=0, a=256, w=512 -> y=512, sat=0, out_valid high after E3.
- len=3, bias=256; pairs (256,512), (128,128), (-256,256) -> y=576 (2+0.25-1+1=2.25), sat=0. Repeat with in_valid gaps of 2 cycles -> same y, latency grows by the gap cycles only.
- Rounding:
  - len=1, a=1, w=128 -> y=1.
  - a=-1, w=128 -> y=0.
  - a=-1, w=129 -> y=-1.
- Saturation:
  - len=4, a=w=32767 -> y=32767, sat=1.
  - len=1, a=32767, w=-32768, bias=-32768 -> y=-32768, sat=1.
- Backpressure and edges:
  - out_ready=0 for 5 cycles -> y stable, start ignored.
  - len=0, bias=-300 -> y=-300 after E1.
- rst asserted mid-ACCUM after 2 of 4 terms -> outputs at reset values immediately, no out_valid.
  - A following start with len=1, a=256, w=256 -> y=256.
